// File: rtl/cms_trace_decoder.sv
// rtl/cms_trace_decoder.sv - unpacks CMS trace packets into timestamped records with per-event totals
module cms_trace_decoder #(
  parameter int XLEN     = 64,
  parameter int INSTR_W  = 32,
  parameter int CLK_W    = 64,
  parameter int CNT_W    = 7,
  parameter int N_EVENTS = 39,
  parameter int ACC_W    = 32,
  localparam int DATA_W  = N_EVENTS*CNT_W + N_EVENTS + XLEN + CLK_W + INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               S_AXIS_tvalid,
  output logic               S_AXIS_tready,
  input  logic [DATA_W-1:0]  S_AXIS_tdata,
  input  logic               S_AXIS_tlast,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic [CLK_W-1:0]   out_delta,
  output logic [CLK_W-1:0]   out_timestamp,
  output logic               out_last,
  output logic [31:0]        out_index,
  input  logic               clear,
  input  logic [5:0]         event_sel,
  output logic [ACC_W-1:0]   event_total,
  output logic               acc_overflow,
  output logic               run_done
);
  localparam int OVF_LO = N_EVENTS*CNT_W;
  localparam int PC_LO  = OVF_LO + N_EVENTS;
  localparam int DLT_LO = PC_LO + XLEN;
  localparam int INS_LO = DLT_LO + CLK_W;

  logic               r_ready_en;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [XLEN-1:0]    r_out_pc;
  logic [CLK_W-1:0]   r_out_delta;
  logic [CLK_W-1:0]   r_out_ts;
  logic               r_out_last;
  logic [31:0]        r_out_index;
  logic [ACC_W-1:0]   r_event_total;
  logic               r_acc_ovf;
  logic               r_restart;
  logic [CLK_W-1:0]   r_ts;
  logic [31:0]        r_index;
  logic [ACC_W-1:0]   r_total [N_EVENTS];

  logic                w_accept;
  logic                w_fresh;
  logic                w_carry_any;
  logic [N_EVENTS-1:0] w_ovf;
  logic [31:0]         w_base_idx;
  logic [CLK_W-1:0]    w_ts_next;
  logic [ACC_W-1:0]    w_sel_total;
  logic [ACC_W:0]      w_sum [N_EVENTS];

  // tready is held low until the first edge after reset so nothing is accepted mid-reset
  assign S_AXIS_tready = r_ready_en & (~r_out_valid | out_ready);
  assign w_accept      = S_AXIS_tvalid & S_AXIS_tready;
  // r_restart defers the end-of-run restart so the final run totals stay readable
  assign w_fresh       = clear | r_restart;
  assign w_ovf         = S_AXIS_tdata[OVF_LO +: N_EVENTS];
  assign w_base_idx    = w_fresh ? 32'd0 : r_index;
  assign w_ts_next     = (r_ts & {CLK_W{~w_fresh}}) + S_AXIS_tdata[DLT_LO +: CLK_W];

  always_comb begin
    w_carry_any = 1'b0;
    w_sel_total = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      w_sum[i] = {1'b0, r_total[i] & {ACC_W{~w_fresh}}}
               + {{(ACC_W-CNT_W+1){1'b0}}, S_AXIS_tdata[i*CNT_W +: CNT_W]}
               + {{(ACC_W-CNT_W){1'b0}}, w_ovf[i], {CNT_W{1'b0}}};
      w_carry_any = w_carry_any | w_sum[i][ACC_W];
      if (event_sel == 6'(i)) w_sel_total = r_total[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_pc      <= '0;
      r_out_delta   <= '0;
      r_out_ts      <= '0;
      r_out_last    <= 1'b0;
      r_out_index   <= '0;
      r_event_total <= '0;
      r_acc_ovf     <= 1'b0;
      r_restart     <= 1'b0;
      r_ts          <= '0;
      r_index       <= '0;
      for (int i = 0; i < N_EVENTS; i++) r_total[i] <= '0;
    end else begin
      r_ready_en    <= 1'b1;
      r_event_total <= w_sel_total;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_instr <= S_AXIS_tdata[INS_LO +: INSTR_W];
        r_out_pc    <= S_AXIS_tdata[PC_LO +: XLEN];
        r_out_delta <= S_AXIS_tdata[DLT_LO +: CLK_W];
        r_out_ts    <= w_ts_next;
        r_out_last  <= S_AXIS_tlast;
        r_out_index <= w_base_idx;
        r_ts        <= w_ts_next;
        r_index     <= w_base_idx + 32'd1;
        r_restart   <= S_AXIS_tlast;
        r_acc_ovf   <= (r_acc_ovf & ~clear) | w_carry_any;
        for (int i = 0; i < N_EVENTS; i++) r_total[i] <= w_sum[i][ACC_W-1:0];
      end else begin
        if (out_ready) r_out_valid <= 1'b0;
        if (clear) begin
          r_ts      <= '0;
          r_index   <= '0;
          r_restart <= 1'b0;
          r_acc_ovf <= 1'b0;
          for (int i = 0; i < N_EVENTS; i++) r_total[i] <= '0;
        end
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_instr     = r_out_instr;
  assign out_pc        = r_out_pc;
  assign out_delta     = r_out_delta;
  assign out_timestamp = r_out_ts;
  assign out_last      = r_out_last;
  assign out_index     = r_out_index;
  assign event_total   = r_event_total;
  assign acc_overflow  = r_acc_ovf;
  assign run_done      = r_out_valid & out_ready & r_out_last;

endmodule

// File: tb/tb_cms_trace_decoder.sv
// tb/tb_cms_trace_decoder.sv - randomized and directed bench for cms_trace_decoder against a packet-level model
module tb_cms_trace_decoder;
  localparam int XLEN     = 64;
  localparam int INSTR_W  = 32;
  localparam int CLK_W    = 64;
  localparam int CNT_W    = 7;
  localparam int N_EVENTS = 39;
  localparam int ACC_W    = 16;
  localparam int DATA_W   = N_EVENTS*CNT_W + N_EVENTS + XLEN + CLK_W + INSTR_W;

  logic               clk;
  logic               rst_n;
  logic               S_AXIS_tvalid;
  logic               S_AXIS_tready;
  logic [DATA_W-1:0]  S_AXIS_tdata;
  logic               S_AXIS_tlast;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;
  logic [CLK_W-1:0]   out_delta;
  logic [CLK_W-1:0]   out_timestamp;
  logic               out_last;
  logic [31:0]        out_index;
  logic               clear;
  logic [5:0]         event_sel;
  logic [ACC_W-1:0]   event_total;
  logic               acc_overflow;
  logic               run_done;

  cms_trace_decoder #(
    .XLEN(XLEN), .INSTR_W(INSTR_W), .CLK_W(CLK_W),
    .CNT_W(CNT_W), .N_EVENTS(N_EVENTS), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_delta(out_delta),
    .out_timestamp(out_timestamp), .out_last(out_last), .out_index(out_index),
    .clear(clear), .event_sel(event_sel), .event_total(event_total),
    .acc_overflow(acc_overflow), .run_done(run_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  logic [CNT_W-1:0]    p_cnt [N_EVENTS];
  logic [N_EVENTS-1:0] p_ovf;
  logic [XLEN-1:0]     p_pc;
  logic [CLK_W-1:0]    p_delta;
  logic [INSTR_W-1:0]  p_instr;

  logic [ACC_W-1:0]    m_tot [N_EVENTS];
  logic [CLK_W-1:0]    m_ts;
  logic [31:0]         m_idx;
  bit                  m_fresh;
  bit                  m_aovf;
  bit                  m_rdy;
  bit                  m_acc;

  bit                  e_valid;
  logic [INSTR_W-1:0]  e_instr;
  logic [XLEN-1:0]     e_pc;
  logic [CLK_W-1:0]    e_delta;
  logic [CLK_W-1:0]    e_ts;
  bit                  e_last;
  logic [31:0]         e_index;
  logic [ACC_W-1:0]    e_evt;

  function automatic logic [DATA_W-1:0] build();
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < N_EVENTS; i++) d[i*CNT_W +: CNT_W] = p_cnt[i];
    d[N_EVENTS*CNT_W +: N_EVENTS] = p_ovf;
    d[N_EVENTS*CNT_W + N_EVENTS +: XLEN] = p_pc;
    d[N_EVENTS*CNT_W + N_EVENTS + XLEN +: CLK_W] = p_delta;
    d[N_EVENTS*CNT_W + N_EVENTS + XLEN + CLK_W +: INSTR_W] = p_instr;
    return d;
  endfunction

  task automatic set_pkt(input logic [INSTR_W-1:0] instr, input logic [XLEN-1:0] pc,
                         input logic [CLK_W-1:0] delta);
    p_instr = instr;
    p_pc    = pc;
    p_delta = delta;
    p_ovf   = '0;
    for (int i = 0; i < N_EVENTS; i++) p_cnt[i] = '0;
  endtask

  task automatic rand_pkt();
    p_instr = $urandom;
    p_pc    = {$urandom, $urandom};
    p_delta = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1000));
    for (int i = 0; i < N_EVENTS; i++) begin
      p_cnt[i] = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
      p_ovf[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic model_zero();
    m_ts  = '0;
    m_idx = '0;
    for (int i = 0; i < N_EVENTS; i++) m_tot[i] = '0;
  endtask

  task automatic model_reset();
    model_zero();
    m_fresh = 0;
    m_aovf  = 0;
    m_rdy   = 0;
    e_valid = 0;
    e_evt   = '0;
  endtask

  task automatic model_accept();
    longint unsigned s;
    if (clear) begin
      model_zero();
      m_aovf = 0;
    end else if (m_fresh) begin
      model_zero();
    end
    e_index = m_idx;
    m_ts    = m_ts + p_delta;
    e_ts    = m_ts;
    e_instr = p_instr;
    e_pc    = p_pc;
    e_delta = p_delta;
    e_last  = S_AXIS_tlast;
    e_valid = 1;
    for (int i = 0; i < N_EVENTS; i++) begin
      s = longint'(m_tot[i]) + longint'(p_cnt[i]) + (p_ovf[i] ? (64'd1 << CNT_W) : 64'd0);
      if (s >= (64'd1 << ACC_W)) m_aovf = 1;
      m_tot[i] = s[ACC_W-1:0];
    end
    m_idx   = m_idx + 32'd1;
    m_fresh = S_AXIS_tlast;
  endtask

  // One clock: advance the model for this edge, then return at negedge+1
  task automatic tick();
    logic [ACC_W-1:0] evt;
    evt = '0;
    for (int i = 0; i < N_EVENTS; i++) if (int'(event_sel) == i) evt = m_tot[i];
    m_acc = rst_n && S_AXIS_tvalid && m_rdy && (!e_valid || out_ready);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_acc) model_accept();
      else begin
        if (out_ready) e_valid = 0;
        if (clear) begin
          model_zero();
          m_aovf  = 0;
          m_fresh = 0;
        end
      end
      e_evt = evt;
      m_rdy = 1;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; S_AXIS_tvalid = 0; S_AXIS_tlast = 0; S_AXIS_tdata = '0;
    out_ready = 0; clear = 0; event_sel = 0;
    model_reset();
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (S_AXIS_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", S_AXIS_tready); end
    n_cmp++; if (out_timestamp !== '0 || out_index !== '0) begin n_fail++; $display("FAIL reset_ts_idx: got %0h/%0h want 0/0", out_timestamp, out_index); end
    n_cmp++; if (event_total !== '0 || acc_overflow !== 1'b0 || run_done !== 1'b0) begin n_fail++; $display("FAIL reset_misc: got %0h/%b/%b want 0/0/0", event_total, acc_overflow, run_done); end
    rst_n = 1;
    tick();
    #1;
    n_cmp++; if (S_AXIS_tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_tready: got %b want 1", S_AXIS_tready); end
  endtask

  task automatic test_single();
    set_pkt(32'h00000013, 64'h80000000, 64'd5);
    p_cnt[0] = 7'd3;
    S_AXIS_tdata = build(); S_AXIS_tvalid = 1; out_ready = 1; event_sel = 0;
    tick();
    S_AXIS_tvalid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_timestamp !== 64'd5 || out_timestamp !== e_ts) begin n_fail++; $display("FAIL single_ts: got %0d want 5", out_timestamp); end
    n_cmp++; if (out_pc !== 64'h80000000 || out_instr !== 32'h13) begin n_fail++; $display("FAIL single_pc_instr: got %0h/%0h want 80000000/13", out_pc, out_instr); end
    n_cmp++; if (out_index !== 32'd0) begin n_fail++; $display("FAIL single_index: got %0d want 0", out_index); end
    tick();
    n_cmp++; if (event_total !== 3 || event_total !== e_evt) begin n_fail++; $display("FAIL single_total: got %0d want 3", event_total); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [CLK_W-1:0] dl [3];
    logic [CLK_W-1:0] ts [3];
    dl[0] = 5; dl[1] = 7; dl[2] = 1;
    ts[0] = 5; ts[1] = 12; ts[2] = 13;
    clear = 1; tick(); clear = 0;
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      set_pkt($urandom, {$urandom, $urandom}, dl[k]);
      S_AXIS_tdata = build(); S_AXIS_tvalid = 1;
      #1;
      n_cmp++; if (S_AXIS_tready !== 1'b1) begin n_fail++; $display("FAIL b2b_tready[%0d]: got %b want 1", k, S_AXIS_tready); end
      tick();
      n_cmp++; if (out_timestamp !== ts[k] || out_index !== 32'(k)) begin n_fail++; $display("FAIL b2b_rec[%0d]: got ts %0d idx %0d want ts %0d idx %0d", k, out_timestamp, out_index, ts[k], k); end
    end
    S_AXIS_tvalid = 0;
    tick();
  endtask

  task automatic test_overflow_bit();
    clear = 1; tick(); clear = 0;
    set_pkt($urandom, '0, 64'd1);
    p_cnt[1] = 7'd2; p_ovf[1] = 1'b1;
    S_AXIS_tdata = build(); S_AXIS_tvalid = 1; event_sel = 1;
    tick();
    S_AXIS_tvalid = 0;
    tick();
    n_cmp++; if (event_total !== 130 || event_total !== e_evt) begin n_fail++; $display("FAIL ovf_bit_total: got %0d want 130", event_total); end
  endtask

  task automatic test_backpressure();
    logic [31:0]        s_idx;
    logic [CLK_W-1:0]   s_ts;
    logic [INSTR_W-1:0] s_instr;
    out_ready = 0;
    rand_pkt(); S_AXIS_tdata = build(); S_AXIS_tvalid = 1;
    tick();
    s_idx = e_index; s_ts = e_ts; s_instr = e_instr;
    rand_pkt(); S_AXIS_tdata = build();
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (S_AXIS_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready[%0d]: got %b want 0", k, S_AXIS_tready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_index !== s_idx || out_timestamp !== s_ts || out_instr !== s_instr) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v%b idx %0d ts %0h want v1 idx %0d ts %0h", k, out_valid, out_index, out_timestamp, s_idx, s_ts);
      end
    end
    out_ready = 1;
    #1;
    n_cmp++; if (S_AXIS_tready !== 1'b1) begin n_fail++; $display("FAIL bp_release_tready: got %b want 1", S_AXIS_tready); end
    tick();
    S_AXIS_tvalid = 0;
    n_cmp++; if (out_valid !== 1'b1 || out_index !== s_idx + 32'd1 || out_instr !== p_instr || out_timestamp !== s_ts + p_delta) begin
      n_fail++; $display("FAIL bp_second: got idx %0d instr %0h want idx %0d instr %0h", out_index, out_instr, s_idx + 32'd1, p_instr);
    end
    tick();
  endtask

  task automatic test_tlast();
    clear = 1; tick(); clear = 0;
    out_ready = 1;
    set_pkt($urandom, '0, 64'd13); S_AXIS_tdata = build(); S_AXIS_tvalid = 1;
    tick();
    set_pkt($urandom, '0, 64'd9); S_AXIS_tdata = build(); S_AXIS_tlast = 1;
    tick();
    n_cmp++; if (out_timestamp !== 64'd22 || out_last !== 1'b1) begin n_fail++; $display("FAIL tlast_rec: got ts %0d last %b want 22 1", out_timestamp, out_last); end
    set_pkt($urandom, '0, 64'd4); S_AXIS_tdata = build(); S_AXIS_tlast = 0;
    #1;
    n_cmp++; if (run_done !== 1'b1) begin n_fail++; $display("FAIL tlast_run_done: got %b want 1", run_done); end
    tick();
    n_cmp++; if (out_timestamp !== 64'd4 || out_index !== 32'd0 || out_last !== 1'b0) begin n_fail++; $display("FAIL tlast_restart: got ts %0d idx %0d want 4 0", out_timestamp, out_index); end
    S_AXIS_tvalid = 0;
    #1;
    n_cmp++; if (run_done !== 1'b0) begin n_fail++; $display("FAIL tlast_run_done_low: got %b want 0", run_done); end
    tick();
  endtask

  task automatic test_clear();
    set_pkt($urandom, '0, 64'd3); p_cnt[0] = 7'd5;
    S_AXIS_tdata = build(); S_AXIS_tvalid = 1; out_ready = 1;
    tick();
    set_pkt($urandom, '0, 64'd6); p_cnt[0] = 7'd1;
    S_AXIS_tdata = build(); clear = 1;
    tick();
    S_AXIS_tvalid = 0; clear = 0; event_sel = 0;
    n_cmp++; if (out_index !== 32'd0 || out_timestamp !== 64'd6) begin n_fail++; $display("FAIL clear_rec: got idx %0d ts %0d want 0 6", out_index, out_timestamp); end
    tick();
    n_cmp++; if (event_total !== 1 || acc_overflow !== 1'b0) begin n_fail++; $display("FAIL clear_total: got %0d ovf %b want 1 0", event_total, acc_overflow); end
  endtask

  task automatic test_acc_wrap();
    clear = 1; tick(); clear = 0;
    out_ready = 1;
    for (int k = 0; k < 257; k++) begin
      set_pkt($urandom, '0, 64'd1); p_cnt[2] = 7'd127; p_ovf[2] = 1'b1;
      S_AXIS_tdata = build(); S_AXIS_tvalid = 1;
      tick();
      n_cmp++; if (out_index !== 32'(k)) begin n_fail++; $display("FAIL wrap_index[%0d]: got %0d want %0d", k, out_index, k); end
    end
    event_sel = 2;
    n_cmp++; if (acc_overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_pre_ovf: got %b want 0", acc_overflow); end
    set_pkt($urandom, '0, 64'd1); p_cnt[2] = 7'd1;
    S_AXIS_tdata = build();
    tick();
    n_cmp++; if (event_total !== {ACC_W{1'b1}}) begin n_fail++; $display("FAIL wrap_max: got %0h want %0h", event_total, {ACC_W{1'b1}}); end
    n_cmp++; if (acc_overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1", acc_overflow); end
    S_AXIS_tvalid = 0;
    tick();
    n_cmp++; if (event_total !== '0) begin n_fail++; $display("FAIL wrap_zero: got %0h want 0", event_total); end
  endtask

  task automatic test_random();
    S_AXIS_tvalid = 0;
    for (int it = 0; it < 400; it++) begin
      if (!S_AXIS_tvalid && $urandom_range(0, 3) != 0) begin
        rand_pkt();
        S_AXIS_tlast  = ($urandom_range(0, 7) == 0);
        S_AXIS_tdata  = build();
        S_AXIS_tvalid = 1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 15) == 0);
      event_sel = 6'($urandom_range(0, 63));
      #1;
      n_cmp++; if (S_AXIS_tready !== (!e_valid || out_ready)) begin n_fail++; $display("FAIL rnd_tready[%0d]: got %b want %b", it, S_AXIS_tready, (!e_valid || out_ready)); end
      n_cmp++; if (run_done !== (e_valid && out_ready && e_last)) begin n_fail++; $display("FAIL rnd_run_done[%0d]: got %b want %b", it, run_done, (e_valid && out_ready && e_last)); end
      tick();
      if (m_acc) S_AXIS_tvalid = 0;
      n_cmp++; if (out_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", it, out_valid, e_valid); end
      if (e_valid) begin
        n_cmp++; if (out_instr !== e_instr || out_pc !== e_pc || out_delta !== e_delta) begin n_fail++; $display("FAIL rnd_fields[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", it, out_instr, out_pc, out_delta, e_instr, e_pc, e_delta); end
        n_cmp++; if (out_timestamp !== e_ts || out_index !== e_index || out_last !== e_last) begin n_fail++; $display("FAIL rnd_ts_idx[%0d]: got %0h/%0d/%b want %0h/%0d/%b", it, out_timestamp, out_index, out_last, e_ts, e_index, e_last); end
      end
      n_cmp++; if (event_total !== e_evt) begin n_fail++; $display("FAIL rnd_total[%0d]: got %0h want %0h", it, event_total, e_evt); end
      n_cmp++; if (acc_overflow !== m_aovf) begin n_fail++; $display("FAIL rnd_acc_ovf[%0d]: got %b want %b", it, acc_overflow, m_aovf); end
    end
    S_AXIS_tvalid = 0; clear = 0; S_AXIS_tlast = 0; out_ready = 1;
    tick();
  endtask

  task automatic test_reset_midpacket();
    out_ready = 0;
    rand_pkt(); S_AXIS_tdata = build(); S_AXIS_tvalid = 1;
    tick();
    S_AXIS_tvalid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_held: got %b want 1", out_valid); end
    rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || S_AXIS_tready !== 1'b0) begin n_fail++; $display("FAIL mid_async: got v%b r%b want v0 r0", out_valid, S_AXIS_tready); end
    tick();
    rst_n = 1; out_ready = 1;
    tick();
    set_pkt($urandom, '0, 64'd11); S_AXIS_tdata = build(); S_AXIS_tvalid = 1;
    tick();
    S_AXIS_tvalid = 0;
    n_cmp++; if (out_index !== 32'd0 || out_timestamp !== 64'd11 || acc_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_restart: got idx %0d ts %0d ovf %b want 0 11 0", out_index, out_timestamp, acc_overflow); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow_bit();
    test_backpressure();
    test_tlast();
    test_clear();
    test_acc_wrap();
    test_random();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
